// File: rtl/audio_serial_tx_if.sv
// Sample-pair handshake plus serial audio outputs of audio_serial_tx.
// master = sample source / line observer, slave = the transmitter.
interface audio_serial_tx_if #(
    parameter int WIDTH = 24
);
    logic [WIDTH-1:0] smp_l_i;
    logic [WIDTH-1:0] smp_r_i;
    logic             smp_valid_i;
    logic             smp_ready_o;
    logic             lrck_o;
    logic             sdata_o;
    logic             underrun_o;

    modport master (
        output smp_l_i,
        output smp_r_i,
        output smp_valid_i,
        input  smp_ready_o,
        input  lrck_o,
        input  sdata_o,
        input  underrun_o
    );

    modport slave (
        input  smp_l_i,
        input  smp_r_i,
        input  smp_valid_i,
        output smp_ready_o,
        output lrck_o,
        output sdata_o,
        output underrun_o
    );
endinterface

// File: rtl/audio_serial_tx.sv
// Serial audio transmitter (I2S / left- / right-justified), outputs launched on rising launchclk.
// Latency: accepted pair starts at the frame after the next boundary, worst case 2*SLOT+OFF+1 cycles.
// Backpressure: single holding register, ready low while full; AUDIO_TX_UNDERRUN_HOLD_EN repeats last pair on underrun.
module audio_serial_tx #(
    parameter int WIDTH  = 24,
    parameter int SLOT   = 32,
    parameter int FORMAT = 0
) (
    input  logic              launchclk,
    input  logic              clr_i,
    audio_serial_tx_if.slave  bus
);

    localparam int FRAME = 2 * SLOT;
    localparam int CW    = $clog2(FRAME);
    localparam int OFF   = (FORMAT == 0) ? 1 : (FORMAT == 1) ? 0 : (SLOT - WIDTH);

    localparam logic [CW-1:0] LAST   = CW'(FRAME - 1);
    localparam logic [CW-1:0] SLOT_C = CW'(SLOT);

    if (WIDTH < 1 || SLOT < 2 || SLOT > 64 || FORMAT < 0 || FORMAT > 2 ||
        WIDTH > SLOT - ((FORMAT == 0) ? 1 : 0)) begin : g_bad_param
        $error("audio_serial_tx: illegal WIDTH/SLOT/FORMAT combination");
    end

    logic [CW-1:0]    cnt;
    logic             lrck_q;
    logic             sdata_q;
    logic             underrun_q;
    logic             hold_full;
    logic [WIDTH-1:0] hold_l;
    logic [WIDTH-1:0] hold_r;
    logic [WIDTH-1:0] cur_l;
    logic [WIDTH-1:0] cur_r;

    logic             boundary;
    logic             accept;
    logic [CW-1:0]    cnt_nxt;
    logic             right_nxt;
    logic [CW-1:0]    pos_nxt;
    logic             hold_full_nxt;
    logic [WIDTH-1:0] hold_l_nxt;
    logic [WIDTH-1:0] hold_r_nxt;
    logic [WIDTH-1:0] cur_l_nxt;
    logic [WIDTH-1:0] cur_r_nxt;
    logic [WIDTH-1:0] cur_sel;
    logic [WIDTH-1:0] shifted;
    logic             sdata_nxt;
    logic             underrun_nxt;
    int               bit_off;

    assign boundary = (cnt == LAST);
    assign accept   = bus.smp_valid_i & ~hold_full;

    always_comb begin
        cnt_nxt       = boundary ? '0 : cnt + 1'b1;
        right_nxt     = (cnt_nxt >= SLOT_C);
        pos_nxt       = right_nxt ? (cnt_nxt - SLOT_C) : cnt_nxt;

        hold_full_nxt = hold_full;
        hold_l_nxt    = hold_l;
        hold_r_nxt    = hold_r;
        cur_l_nxt     = cur_l;
        cur_r_nxt     = cur_r;
        underrun_nxt  = 1'b0;

        // An accept on the boundary edge only fills holding; it never bypasses into cur.
        if (boundary) begin
            if (hold_full) begin
                cur_l_nxt     = hold_l;
                cur_r_nxt     = hold_r;
                hold_full_nxt = 1'b0;
            end else begin
                underrun_nxt  = 1'b1;
`ifdef AUDIO_TX_UNDERRUN_HOLD_EN
                cur_l_nxt     = cur_l;
                cur_r_nxt     = cur_r;
`else
                cur_l_nxt     = '0;
                cur_r_nxt     = '0;
`endif
            end
        end

        if (accept) begin
            hold_full_nxt = 1'b1;
            hold_l_nxt    = bus.smp_l_i;
            hold_r_nxt    = bus.smp_r_i;
        end
    end

    // Output bit is computed for the slot position the counter moves to, so
    // sdata_o and lrck_o always line up with the registered cnt.
    always_comb begin
        cur_sel   = right_nxt ? cur_r_nxt : cur_l_nxt;
        bit_off   = int'(pos_nxt) - OFF;
        shifted   = '0;
        sdata_nxt = 1'b0;
        if (bit_off >= 0 && bit_off < WIDTH) begin
            shifted   = cur_sel << bit_off;
            sdata_nxt = shifted[WIDTH-1];
        end
    end

    always_ff @(posedge launchclk or posedge clr_i) begin
        if (clr_i) begin
            cnt        <= '0;
            lrck_q     <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            hold_full  <= 1'b0;
            hold_l     <= '0;
            hold_r     <= '0;
            cur_l      <= '0;
            cur_r      <= '0;
        end else begin
            cnt        <= cnt_nxt;
            lrck_q     <= right_nxt;
            sdata_q    <= sdata_nxt;
            underrun_q <= underrun_nxt;
            hold_full  <= hold_full_nxt;
            hold_l     <= hold_l_nxt;
            hold_r     <= hold_r_nxt;
            cur_l      <= cur_l_nxt;
            cur_r      <= cur_r_nxt;
        end
    end

    assign bus.smp_ready_o = ~hold_full;
    assign bus.lrck_o      = lrck_q;
    assign bus.sdata_o     = sdata_q;
    assign bus.underrun_o  = underrun_q;

endmodule

// File: tb/tb_audio_serial_tx.sv
// Directed bench for audio_serial_tx: I2S, LJ and RJ instances share clock and reset.
module tb_audio_serial_tx;

    logic clk;
    logic clr;
    int   cyc;
    int   n_tests;
    int   n_fail;

`ifdef AUDIO_TX_UNDERRUN_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    audio_serial_tx_if #(.WIDTH(24)) bus0 ();
    audio_serial_tx_if #(.WIDTH(24)) bus1 ();
    audio_serial_tx_if #(.WIDTH(24)) bus2 ();

    audio_serial_tx #(.WIDTH(24), .SLOT(32), .FORMAT(0)) dut_i2s (.launchclk(clk), .clr_i(clr), .bus(bus0));
    audio_serial_tx #(.WIDTH(24), .SLOT(32), .FORMAT(1)) dut_lj  (.launchclk(clk), .clr_i(clr), .bus(bus1));
    audio_serial_tx #(.WIDTH(24), .SLOT(32), .FORMAT(2)) dut_rj  (.launchclk(clk), .clr_i(clr), .bus(bus2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // All driving and sampling happens on the falling edge; cyc%64 tracks the DUT counter.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_cnt(input int c);
        for (int i = 0; i < 64 && (cyc % 64) != c; i++) step();
    endtask

    task automatic capture(output logic [63:0] d0, output logic [63:0] d1,
                           output logic [63:0] d2, output logic [63:0] lr);
        d0 = '0; d1 = '0; d2 = '0; lr = '0;
        for (int i = 0; i < 64; i++) begin
            d0[cyc % 64] = bus0.sdata_o;
            d1[cyc % 64] = bus1.sdata_o;
            d2[cyc % 64] = bus2.sdata_o;
            lr[cyc % 64] = bus0.lrck_o;
            step();
        end
    endtask

    task automatic send0(input logic [23:0] l, input logic [23:0] r);
        bus0.smp_l_i = l; bus0.smp_r_i = r; bus0.smp_valid_i = 1'b1;
        step();
        bus0.smp_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if (bus0.lrck_o !== 1'b0)      begin n_fail++; $display("FAIL reset_lrck: got %b want 0", bus0.lrck_o); end
        n_tests++; if (bus0.sdata_o !== 1'b0)     begin n_fail++; $display("FAIL reset_sdata: got %b want 0", bus0.sdata_o); end
        n_tests++; if (bus0.smp_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus0.smp_ready_o); end
        n_tests++; if (bus0.underrun_o !== 1'b0)  begin n_fail++; $display("FAIL reset_underrun: got %b want 0", bus0.underrun_o); end
        clr = 1'b0;
        cyc = 0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 128; i++) begin
            n_tests++; if (bus0.lrck_o !== ((cyc % 64) >= 32))
                begin n_fail++; $display("FAIL idle_lrck cnt=%0d: got %b", cyc % 64, bus0.lrck_o); end
            n_tests++; if (bus0.sdata_o !== 1'b0 || bus1.sdata_o !== 1'b0 || bus2.sdata_o !== 1'b0)
                begin n_fail++; $display("FAIL idle_sdata cnt=%0d: got %b%b%b want 000", cyc % 64, bus0.sdata_o, bus1.sdata_o, bus2.sdata_o); end
            n_tests++; if (bus0.smp_ready_o !== 1'b1)
                begin n_fail++; $display("FAIL idle_ready cnt=%0d: got %b want 1", cyc % 64, bus0.smp_ready_o); end
            n_tests++; if (bus0.underrun_o !== (cyc == 64))
                begin n_fail++; $display("FAIL idle_underrun cyc=%0d: got %b want %b", cyc, bus0.underrun_o, cyc == 64); end
            step();
        end
    endtask

    task automatic test_formats();
        logic [63:0] d0, d1, d2, lr;
        wait_cnt(10);
        bus0.smp_l_i = 24'h800001; bus0.smp_r_i = 24'h7FFFFF;
        bus1.smp_l_i = 24'hC00000; bus1.smp_r_i = 24'h000000;
        bus2.smp_l_i = 24'hC00000; bus2.smp_r_i = 24'h000000;
        bus0.smp_valid_i = 1'b1; bus1.smp_valid_i = 1'b1; bus2.smp_valid_i = 1'b1;
        step();
        bus0.smp_valid_i = 1'b0; bus1.smp_valid_i = 1'b0; bus2.smp_valid_i = 1'b0;
        n_tests++; if (bus0.smp_ready_o !== 1'b0 || bus1.smp_ready_o !== 1'b0 || bus2.smp_ready_o !== 1'b0)
            begin n_fail++; $display("FAIL fmt_ready_after_accept: got %b%b%b want 000", bus0.smp_ready_o, bus1.smp_ready_o, bus2.smp_ready_o); end
        wait_cnt(63);
        n_tests++; if (bus0.smp_ready_o !== 1'b0) begin n_fail++; $display("FAIL fmt_ready_cnt63: got %b want 0", bus0.smp_ready_o); end
        step();
        n_tests++; if (bus0.underrun_o !== 1'b0 || bus1.underrun_o !== 1'b0 || bus2.underrun_o !== 1'b0)
            begin n_fail++; $display("FAIL fmt_no_underrun: got %b%b%b want 000", bus0.underrun_o, bus1.underrun_o, bus2.underrun_o); end
        n_tests++; if (bus0.smp_ready_o !== 1'b1) begin n_fail++; $display("FAIL fmt_ready_after_boundary: got %b want 1", bus0.smp_ready_o); end
        capture(d0, d1, d2, lr);
        n_tests++; if (d0[31:0] !== 32'h01000002)  begin n_fail++; $display("FAIL i2s_left: got %h want 01000002", d0[31:0]); end
        n_tests++; if (d0[63:32] !== 32'h01FFFFFC) begin n_fail++; $display("FAIL i2s_right: got %h want 01fffffc", d0[63:32]); end
        n_tests++; if (lr !== 64'hFFFFFFFF_00000000) begin n_fail++; $display("FAIL i2s_lrck: got %h", lr); end
        n_tests++; if (d1 !== 64'h00000000_00000003) begin n_fail++; $display("FAIL lj_frame: got %h want 3", d1); end
        n_tests++; if (d2 !== 64'h00000000_00000300) begin n_fail++; $display("FAIL rj_frame: got %h want 300", d2); end
        n_tests++; if (bus0.underrun_o !== 1'b1) begin n_fail++; $display("FAIL fmt_underrun_next: got %b want 1", bus0.underrun_o); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] va, vb, d1, d2, lr;
        int n;
        wait_cnt(5);
        bus0.smp_l_i = 24'hF00000; bus0.smp_r_i = 24'h000001; bus0.smp_valid_i = 1'b1;
        step();
        bus0.smp_l_i = 24'h000000; bus0.smp_r_i = 24'hFFFFFF;
        n = 0;
        while (bus0.smp_ready_o !== 1'b1 && n < 130) begin step(); n++; end
        n_tests++; if (bus0.smp_ready_o !== 1'b1 || (cyc % 64) != 0 || n != 58)
            begin n_fail++; $display("FAIL b2b_ready_return: ready=%b cnt=%0d waited=%0d want 1/0/58", bus0.smp_ready_o, cyc % 64, n); end
        n_tests++; if (bus0.underrun_o !== 1'b0) begin n_fail++; $display("FAIL b2b_underrun_a: got %b want 0", bus0.underrun_o); end
        fork
            begin @(posedge clk); #1; bus0.smp_valid_i = 1'b0; end
        join_none
        capture(va, d1, d2, lr);
        n_tests++; if (bus0.underrun_o !== 1'b0) begin n_fail++; $display("FAIL b2b_underrun_b: got %b want 0", bus0.underrun_o); end
        capture(vb, d1, d2, lr);
        n_tests++; if (va !== 64'h01000000_0000001E) begin n_fail++; $display("FAIL b2b_frame_a: got %h want 010000000000001e", va); end
        n_tests++; if (vb !== 64'h01FFFFFE_00000000) begin n_fail++; $display("FAIL b2b_frame_b: got %h want 01fffffe00000000", vb); end
        n_tests++; if (bus0.underrun_o !== 1'b1) begin n_fail++; $display("FAIL b2b_underrun_end: got %b want 1", bus0.underrun_o); end
    endtask

    task automatic test_accept_at_boundary();
        logic [63:0] vh, vc, d1, d2, lr, exp_h;
        exp_h = HOLD ? 64'h01FFFFFE_00000000 : 64'h0;
        wait_cnt(63);
        n_tests++; if (bus0.smp_ready_o !== 1'b1) begin n_fail++; $display("FAIL bnd_ready_pre: got %b want 1", bus0.smp_ready_o); end
        send0(24'h000003, 24'hC00000);
        n_tests++; if (bus0.underrun_o !== 1'b1) begin n_fail++; $display("FAIL bnd_underrun: got %b want 1", bus0.underrun_o); end
        n_tests++; if (bus0.smp_ready_o !== 1'b0) begin n_fail++; $display("FAIL bnd_ready_post: got %b want 0", bus0.smp_ready_o); end
        capture(vh, d1, d2, lr);
        n_tests++; if (vh !== exp_h) begin n_fail++; $display("FAIL bnd_underrun_frame: got %h want %h", vh, exp_h); end
        n_tests++; if (bus0.underrun_o !== 1'b0 || bus0.smp_ready_o !== 1'b1)
            begin n_fail++; $display("FAIL bnd_copy: underrun=%b ready=%b want 0/1", bus0.underrun_o, bus0.smp_ready_o); end
        capture(vc, d1, d2, lr);
        n_tests++; if (vc !== 64'h00000006_01800000) begin n_fail++; $display("FAIL bnd_frame_c: got %h want 0000000601800000", vc); end
    endtask

    task automatic test_underrun_hold();
        logic [63:0] vp, vu, d1, d2, lr, exp_u;
        exp_u = HOLD ? 64'h0109854C_00D45890 : 64'h0;
        wait_cnt(20);
        send0(24'h123456, 24'h654321);
        wait_cnt(0);
        n_tests++; if (bus0.underrun_o !== 1'b0) begin n_fail++; $display("FAIL hold_no_underrun: got %b want 0", bus0.underrun_o); end
        capture(vp, d1, d2, lr);
        n_tests++; if (vp !== 64'h0109854C_00D45890) begin n_fail++; $display("FAIL hold_frame_p: got %h want 0109854c00d45890", vp); end
        n_tests++; if (bus0.underrun_o !== 1'b1) begin n_fail++; $display("FAIL hold_underrun: got %b want 1", bus0.underrun_o); end
        capture(vu, d1, d2, lr);
        n_tests++; if (vu !== exp_u) begin n_fail++; $display("FAIL hold_repeat_frame: got %h want %h", vu, exp_u); end
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] vz, d1, d2, lr;
        wait_cnt(2);
        send0(24'h123456, 24'h654321);
        wait_cnt(0);
        wait_cnt(5);
        n_tests++; if (bus0.smp_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready_pre_q: got %b want 1", bus0.smp_ready_o); end
        send0(24'hABCDEF, 24'hFEDCBA);
        wait_cnt(40);
        n_tests++; if (bus0.lrck_o !== 1'b1 || bus0.sdata_o !== 1'b1 || bus0.smp_ready_o !== 1'b0)
            begin n_fail++; $display("FAIL rst_pre_state: lrck=%b sdata=%b ready=%b want 1/1/0", bus0.lrck_o, bus0.sdata_o, bus0.smp_ready_o); end
        clr = 1'b1;
        #1;
        n_tests++; if (bus0.lrck_o !== 1'b0 || bus0.sdata_o !== 1'b0 || bus0.smp_ready_o !== 1'b1 || bus0.underrun_o !== 1'b0)
            begin n_fail++; $display("FAIL rst_immediate: lrck=%b sdata=%b ready=%b underrun=%b want 0/0/1/0", bus0.lrck_o, bus0.sdata_o, bus0.smp_ready_o, bus0.underrun_o); end
        repeat (3) @(negedge clk);
        clr = 1'b0;
        cyc = 0;
        capture(vz, d1, d2, lr);
        n_tests++; if (vz !== 64'h0) begin n_fail++; $display("FAIL rst_first_frame: got %h want 0", vz); end
        n_tests++; if (lr !== 64'hFFFFFFFF_00000000) begin n_fail++; $display("FAIL rst_lrck_restart: got %h", lr); end
        n_tests++; if (bus0.underrun_o !== 1'b1 || bus0.smp_ready_o !== 1'b1)
            begin n_fail++; $display("FAIL rst_first_underrun: underrun=%b ready=%b want 1/1", bus0.underrun_o, bus0.smp_ready_o); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        clr     = 1'b1;
        bus0.smp_l_i = '0; bus0.smp_r_i = '0; bus0.smp_valid_i = 1'b0;
        bus1.smp_l_i = '0; bus1.smp_r_i = '0; bus1.smp_valid_i = 1'b0;
        bus2.smp_l_i = '0; bus2.smp_r_i = '0; bus2.smp_valid_i = 1'b0;
        test_reset();
        test_idle();
        test_formats();
        test_back_to_back();
        test_accept_at_boundary();
        test_underrun_hold();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_serial_tx.md
Name: audio_serial_tx

Overview:
- Serial audio transmitter: accepts parallel stereo sample pairs over a valid/ready handshake and shifts them out bit-serially with a word-select (LR) clock.
- Supports I2S, left-justified and right-justified formats.
- Launch-side counterpart to the edge-aligning receive path: all outputs are launched on rising launchclk, for capture by a downstream latch stage or external DAC on the opposite bit-clock edge.

Parameters:
- WIDTH, 24: sample width in bits (smp_l_i, smp_r_i). Legal range 1..SLOT-(FORMAT==0).
- SLOT, 32: bit-clock cycles per channel slot; frame = 2*SLOT cycles. Legal range 2..64.
- FORMAT, 0: 0 = I2S (1-bit delay after LR edge), 1 = left-justified, 2 = right-justified.

Ports:
- launchclk  in  1  bit clock; all state updates on its rising edge
- clr_i  in  1  reset
- smp_l_i  in  WIDTH  left sample, two's complement, MSB first on wire
- smp_r_i  in  WIDTH  right sample
- smp_valid_i  in  1  sample pair valid
- smp_ready_o  out  1  holding register empty, pair accepted when valid&ready
- lrck_o  out  1  word select: 0 = left slot, 1 = right slot
- sdata_o  out  1  serial data
- underrun_o  out  1  one-cycle pulse, frame boundary with no sample pending

Interface (already decided): reset clr_i, asynchronous, active-high; clock launchclk.

Behaviour:
- Reset values (immediate on clr_i, async): bit counter cnt=0, lrck_o=0, sdata_o=0, smp_ready_o=1, underrun_o=0. Holding register empty and cleared; frame registers (cur_l, cur_r) = 0.
- Counter: cnt runs 0..2*SLOT-1 and wraps to 0. Slot position p = cnt mod SLOT. Slot is left when cnt<SLOT.
- lrck_o: registered, equal to (cnt>=SLOT) for the current bit. It toggles on the edge that starts p=0 of each slot.
- Data start offset OFF: 1 for I2S, 0 for LJ, SLOT-WIDTH for RJ.
- sdata_o: registered.
  - For OFF <= p < OFF+WIDTH: sdata_o = cur[WIDTH-1-(p-OFF)], where cur is cur_l in the left slot and cur_r in the right slot.
  - Otherwise sdata_o = 0. Padding bits are always 0; there is no sign extension.
- Handshake:
  - smp_ready_o=1 while the holding register is empty.
  - Accept on an edge with valid&ready: the holding register captures both channels, and smp_ready_o=0 from the next cycle.
  - valid while ready=0 is ignored. The source must hold the pair.
- Frame boundary (edge at cnt=2*SLOT-1):
  - Holding full: copy to cur_l/cur_r (first used at the next cnt=0), empty the holding register, smp_ready_o=1 from the next cycle.
  - Holding empty: underrun_o=1 for exactly that next cycle. Frame registers are updated per the Optional Feature.
- Simultaneous accept and boundary: when holding is empty and valid&ready coincide with cnt=2*SLOT-1, the pair is accepted into holding and the boundary still counts as an underrun. There is no bypass; the pair plays one frame later.
- Latency: an accepted pair starts on the wire at the first frame start after the next boundary, i.e. MSB of left at cnt=OFF of that frame. Worst case is 2*SLOT+OFF+1 cycles after the accept.
- Reset mid-frame: the frame is aborted with no partial completion. The first post-reset frame transmits zeros and flags underrun at its end unless a pair has been accepted first.

Optional Feature:
- AUDIO_TX_UNDERRUN_HOLD_EN defined: on underrun, cur_l/cur_r keep their previous values, so the last pair is repeated.
- Undefined: on underrun, cur_l/cur_r are cleared to 0 (silence).
- underrun_o behaves identically in both cases.

Test Plan:
- Idle after reset (defaults), valid=0 -> sdata_o=0 throughout; lrck_o low cnt 0-31, high 32-63; underrun_o pulses once per 64 cycles; smp_ready_o stays 1.
- I2S, L=0x800001, R=0x7FFFFF accepted in frame N -> frame N+1:
  - left p=0 is 0, p=1 is 1, p=2..23 are 0, p=24 is 1, p=25..31 are 0;
  - right p=1 is 0, p=2..24 are 1, others 0;
  - no underrun at the end of frame N.
- FORMAT=2, L=0xC00000 -> left p=0..7 are 0, p=8 and p=9 are 1, p=10..31 are 0. FORMAT=1, same L -> p=0 and p=1 are 1, rest 0.
- Back-to-back pairs A,B with valid held high -> A accepted, ready=0 until the cycle after the boundary, then B accepted; A and B transmitted in consecutive frames with no underrun.
- valid&ready arriving exactly at cnt=63 with holding empty -> underrun_o pulse, pair transmitted one frame later. clr_i asserted at cnt=40 -> outputs and ready return to reset values immediately, cnt restarts at 0 on release.
- Underrun after pair 0x123456/0x654321:
  - macro defined: repeated frame carries 0x123456/0x654321;
  - macro undefined: all-zero frame;
  - underrun_o=1 in both builds.
